fifo_stream_reader: RTL

//  Read-side engine for the 16x4 synchronous FIFO. Issues rd pulses against
//  the FIFO's empty flag and absorbs the FIFO's 1-cycle registered read latency.
//  Re-emits words as a valid/ready stream with packet framing (m_last).

---
 rtl/fifo_stream_reader.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side engine for a small synchronous FIFO: issues read strobes, absorbs the
// one-cycle read latency in a 3-entry skid buffer and re-emits words as a framed stream.
module fifo_stream_reader #(
    parameter int DW      = 4,
    parameter int PKT_LEN = 4,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          busy,
    output logic [CW-1:0] words_out,
    output logic [1:0]    dbg_state
);

    // Stream handshake: a word moves when m_valid & m_ready at posedge; m_valid,
    // m_data and m_last never change while m_valid is high and m_ready is low.

    localparam int CNTW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_buf [0:2];
    logic [DW-1:0]   w_buf_nxt [0:2];
    logic [1:0]      r_occ;
    logic            r_inflight;
    logic [CNTW-1:0] r_cnt;
    logic [CW-1:0]   r_words;
    logic [2:0]      w_fill;
    logic [1:0]      w_wr_idx;
    logic            w_xfer;
    logic            w_rd;

    // Space is reserved for the word already in flight, so m_ready never reaches fifo_rd.
    assign w_fill   = {1'b0, r_occ} + {2'b00, r_inflight};
    assign w_rd     = (r_state == RUN) & en & ~fifo_empty & (w_fill < 3'd3);
    assign w_xfer   = m_valid & m_ready;
    assign w_wr_idx = r_occ - {1'b0, w_xfer};

    assign fifo_rd   = w_rd;
    assign m_valid   = (r_occ != 2'd0);
    assign m_data    = r_buf[0];
    assign m_last    = m_valid & (r_cnt == CNTW'(PKT_LEN - 1));
    assign busy      = (r_state != IDLE);
    assign words_out = r_words;
    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (en) w_state_nxt = RUN;
            RUN:     if (!en) w_state_nxt = DRAIN;
            DRAIN: begin
                if (en)
                    w_state_nxt = RUN;
                else if (!r_inflight && (r_occ == 2'd0))
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Head is always entry 0: a pop shifts down, the captured word lands behind the survivors.
    always_comb begin
        w_buf_nxt = r_buf;
        if (w_xfer) begin
            w_buf_nxt[0] = r_buf[1];
            w_buf_nxt[1] = r_buf[2];
        end
        if (r_inflight && (w_wr_idx != 2'd3))
            w_buf_nxt[w_wr_idx] = fifo_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_cnt      <= '0;
            r_words    <= '0;
            for (int i = 0; i < 3; i++)
                r_buf[i] <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_inflight <= w_rd;
            r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_xfer};
            for (int i = 0; i < 3; i++)
                r_buf[i] <= w_buf_nxt[i];
            if (w_xfer) begin
                r_words <= r_words + CW'(1);
                if (r_cnt == CNTW'(PKT_LEN - 1))
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + CNTW'(1);
            end
        end
    end

endmodule
